dst_fifo: RTL and testbench

//  Destination buffer directly downstream of the compress/decompress unit's output packer.

---
 rtl/dst_fifo_if.sv | 47 ++++
 rtl/dst_fifo.sv | 115 +++++++++++
 tb/tb_dst_fifo.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dst_fifo_if.sv
// Write/read handshake bundle for dst_fifo.
// DST_FIFO_STAT_EN adds the ovf_err/unf_err/hwm status signals.
interface dst_fifo_if
`ifdef DST_FIFO_STAT_EN
    #(parameter int unsigned DEPTH_LOG2 = 4)
`endif
    ;
    logic [63:0] m_dst;
    logic        m_dst_putn;
    logic        m_dst_last;
    logic        m_endn;
    logic        m_dst_full;
    logic        m_dst_almost_full;
    logic [63:0] rd_data;
    logic        rd_last;
    logic        rd_valid;
    logic        rd_ready;
    logic        job_done;
    logic [31:0] words_out;
`ifdef DST_FIFO_STAT_EN
    logic                ovf_err;
    logic                unf_err;
    logic [DEPTH_LOG2:0] hwm;

    modport master (
        output m_dst, m_dst_putn, m_dst_last, m_endn, rd_ready,
        input  m_dst_full, m_dst_almost_full, rd_data, rd_last, rd_valid,
               job_done, words_out, ovf_err, unf_err, hwm
    );
    modport slave (
        input  m_dst, m_dst_putn, m_dst_last, m_endn, rd_ready,
        output m_dst_full, m_dst_almost_full, rd_data, rd_last, rd_valid,
               job_done, words_out, ovf_err, unf_err, hwm
    );
`else
    modport master (
        output m_dst, m_dst_putn, m_dst_last, m_endn, rd_ready,
        input  m_dst_full, m_dst_almost_full, rd_data, rd_last, rd_valid,
               job_done, words_out
    );
    modport slave (
        input  m_dst, m_dst_putn, m_dst_last, m_endn, rd_ready,
        output m_dst_full, m_dst_almost_full, rd_data, rd_last, rd_valid,
               job_done, words_out
    );
`endif
endinterface

// File: rtl/dst_fifo.sv
// Destination buffer between the output packer and the DMA write engine, with job-end tracking.
// Optional DST_FIFO_STAT_EN adds sticky overflow/underflow flags and a high-water mark.
module dst_fifo #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input logic         wb_clk_i,
    input logic         wb_rst_n,
    input logic         clr,
    dst_fifo_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_AFULL = (DEPTH_LOG2 + 1)'(DEPTH - AFULL_MARGIN);

    typedef enum logic {IDLE, PEND} end_state_t;

    logic [64:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic [31:0]           words_out;
    end_state_t            state;
    logic                  full;
    logic                  valid;
    logic                  wr_en;
    logic                  rd_en;
    logic                  drained;

    assign full    = (count == CNT_FULL);
    assign valid   = (count != '0);
    assign wr_en   = !bus.m_dst_putn && !full;
    assign rd_en   = valid && bus.rd_ready;
    // A put in the same cycle counts as outstanding data, so it blocks the drain.
    assign drained = (state == PEND) && (count == '0) && !wr_en;

    always_comb begin
        count_nxt = count + (DEPTH_LOG2 + 1)'(wr_en) - (DEPTH_LOG2 + 1)'(rd_en);
    end

    assign bus.m_dst_full        = full;
    assign bus.m_dst_almost_full = (count >= CNT_AFULL);
    assign bus.rd_valid          = valid;
    assign bus.rd_data           = mem[rptr][63:0];
    assign bus.rd_last           = valid && mem[rptr][64];
    assign bus.job_done          = drained && !clr;
    assign bus.words_out         = words_out;

    always_ff @(posedge wb_clk_i) begin
        if (wr_en && !clr) begin
            mem[wptr] <= {bus.m_dst_last, bus.m_dst};
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            words_out <= '0;
            state     <= IDLE;
        end else if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            words_out <= '0;
            state     <= IDLE;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) begin
                rptr      <= rptr + 1'b1;
                words_out <= words_out + 32'd1;
            end
            count <= count_nxt;
            case (state)
                IDLE:    if (!bus.m_endn) state <= PEND;
                PEND:    if (drained) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DST_FIFO_STAT_EN
    logic                ovf_err;
    logic                unf_err;
    logic [DEPTH_LOG2:0] hwm;
    logic                last_rd;

    assign bus.ovf_err = ovf_err;
    assign bus.unf_err = unf_err;
    assign bus.hwm     = hwm;

    // last_rd marks that the pending job's final word has left; underflow is only an error before that.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
            hwm     <= '0;
            last_rd <= 1'b0;
        end else if (clr) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
            hwm     <= '0;
            last_rd <= 1'b0;
        end else begin
            if (!bus.m_dst_putn && full) ovf_err <= 1'b1;
            if (bus.rd_ready && !valid && (state == PEND) && !last_rd) unf_err <= 1'b1;
            if (count_nxt > hwm) hwm <= count_nxt;
            if (drained) last_rd <= 1'b0;
            else if (rd_en && mem[rptr][64]) last_rd <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dst_fifo.sv
// Self-checking bench for dst_fifo: directed scenarios plus random traffic against a queue model.
module tb_dst_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

`ifdef DST_FIFO_STAT_EN
    dst_fifo_if #(.DEPTH_LOG2(4)) bus();
`else
    dst_fifo_if bus();
`endif

    dst_fifo #(.DEPTH_LOG2(4), .AFULL_MARGIN(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .clr      (clr),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int jd_seen = 0;

    logic [64:0] q[$];
    bit          m_pend = 0;
    bit          m_ls = 0;
    bit          m_ovf = 0;
    bit          m_unf = 0;
    int          m_hwm = 0;
    logic [31:0] m_words = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model, clock.
    task automatic step(input bit putn, input logic [63:0] d, input bit last,
                        input bit endn, input bit rdy, input bit c);
        int  sz;
        bit  f, v, wr, rd, jd;
        logic [64:0] head;
        bus.m_dst_putn = putn;
        bus.m_dst      = d;
        bus.m_dst_last = last;
        bus.m_endn     = endn;
        bus.rd_ready   = rdy;
        clr            = c;
        #1;
        sz = q.size();
        f  = (sz == DEPTH);
        v  = (sz != 0);
        wr = !putn && !f;
        rd = v && rdy;
        jd = m_pend && (sz == 0) && !wr;
        chk("rd_valid", bus.rd_valid, v);
        chk("full", bus.m_dst_full, f);
        chk("almost_full", bus.m_dst_almost_full, sz >= DEPTH - 2);
        chk("job_done", bus.job_done, jd && !c);
        chk("words_out", bus.words_out, m_words);
        if (v) begin
            head = q[0];
            chk("rd_data", bus.rd_data, head[63:0]);
            chk("rd_last", bus.rd_last, head[64]);
        end else begin
            chk("rd_last_empty", bus.rd_last, 0);
        end
`ifdef DST_FIFO_STAT_EN
        chk("ovf_err", bus.ovf_err, m_ovf);
        chk("unf_err", bus.unf_err, m_unf);
        chk("hwm", bus.hwm, m_hwm);
`endif
        if (bus.job_done) jd_seen++;
        if (c) begin
            q.delete();
            m_pend = 0; m_ls = 0; m_ovf = 0; m_unf = 0; m_hwm = 0; m_words = '0;
        end else begin
            if (!putn && f) m_ovf = 1;
            if (rdy && !v && m_pend && !m_ls) m_unf = 1;
            if (jd) m_ls = 0;
            else if (rd && q[0][64]) m_ls = 1;
            if (rd) begin
                void'(q.pop_front());
                m_words = m_words + 32'd1;
            end
            if (wr) q.push_back({last, d});
            if (!m_pend && !endn) m_pend = 1;
            else if (jd) m_pend = 0;
            if (q.size() > m_hwm) m_hwm = q.size();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, 64'd0, 1'b0, 1'b1, rdy, 1'b0);
    endtask

    initial begin
        int jd0;
        bus.m_dst_putn = 1'b1;
        bus.m_dst      = '0;
        bus.m_dst_last = 1'b0;
        bus.m_endn     = 1'b1;
        bus.rd_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_full", bus.m_dst_full, 0);
        chk("rst_afull", bus.m_dst_almost_full, 0);
        chk("rst_job_done", bus.job_done, 0);
        chk("rst_words_out", bus.words_out, 0);
        idle(1'b0);

        // Fill to full, one dropped put, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 64'(i), 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 12) chk("afull_after_13", bus.m_dst_almost_full, 0);
            if (i == 13) chk("afull_after_14", bus.m_dst_almost_full, 1);
            if (i == 14) chk("full_after_15", bus.m_dst_full, 0);
        end
        chk("full_after_16", bus.m_dst_full, 1);
        step(1'b0, 64'd99, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef DST_FIFO_STAT_EN
        chk("stat_ovf_set", bus.ovf_err, 1);
        chk("stat_hwm_16", bus.hwm, 16);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", bus.rd_data, 64'(i));
            idle(1'b1);
        end
        chk("drain_empty", bus.rd_valid, 0);

        // Continuous streaming
        for (int i = 0; i < 100; i++) step(1'b0, 64'(1000 + i), 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        chk("stream_words_out", bus.words_out, 116);

        // Job end with the last put and m_endn in the same cycle
        jd0 = jd_seen;
        for (int i = 0; i < 5; i++) step(1'b0, 64'(200 + i), i == 4, i != 4, 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        chk("job_no_early_done", jd_seen - jd0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("job_rd_last", bus.rd_last, i == 4);
            idle(1'b1);
        end
        chk("job_done_pulse", bus.job_done, 1);
        idle(1'b0);
        chk("job_done_once", jd_seen - jd0, 1);

        // Full + read + put in the same cycle
        for (int i = 0; i < DEPTH; i++) step(1'b0, 64'(300 + i), 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'd77, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("frp_not_full", bus.m_dst_full, 0);
        chk("frp_head", bus.rd_data, 301);
        repeat (DEPTH) idle(1'b1);

        // Flush mid-job
        for (int i = 0; i < 7; i++) step(1'b0, 64'(400 + i), 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        jd0 = jd_seen;
        step(1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_rd_valid", bus.rd_valid, 0);
        chk("flush_words_out", bus.words_out, 0);
`ifdef DST_FIFO_STAT_EN
        chk("stat_ovf_clr", bus.ovf_err, 0);
        chk("stat_hwm_clr", bus.hwm, 0);
`endif
        repeat (4) idle(1'b1);
        chk("flush_no_done", jd_seen - jd0, 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 2) == 0, {$urandom, $urandom}, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 19) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) == 0);
        end
        repeat (DEPTH + 2) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
